// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory block reader.
package imem_pkg;
  localparam int BLOCK_W          = 128;
  localparam int READ_LATENCY_DEF = 4;
  localparam int CNT_W            = 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/imem_latency_counter.sv
// Loadable down-counter that times the fixed memory read latency.
module imem_latency_counter
  import imem_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset)                      r_count <= '0;
    else if (load)                  r_count <= value;
    else if (dec && r_count != '0)  r_count <= r_count - W'(1);
  end

  assign zero = (r_count == '0);
endmodule

// File: rtl/imem_block_reader.sv
// Byte-programmable instruction memory returning 16-byte blocks after a
// fixed latency, with a busywait handshake toward the instruction cache.
module imem_block_reader
  import imem_pkg::*;
#(
  parameter int READ_LATENCY = READ_LATENCY_DEF,
  parameter int ADDR_W       = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               read,
  input  logic [ADDR_W-1:0]  address,
  output logic [BLOCK_W-1:0] readdata,
  output logic               busywait,
  input  logic               prog_en,
  input  logic [ADDR_W+3:0]  prog_addr,
  input  logic [7:0]         prog_data
);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(READ_LATENCY - 1);

  state_t             r_state, w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [BLOCK_W-1:0] r_readdata;
  logic [7:0]         r_mem [2**(ADDR_W+4)];
  logic [BLOCK_W-1:0] w_block;
  logic               w_load, w_dec, w_zero, w_cap, w_busy;

  imem_latency_counter #(.W(CNT_W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .load  (w_load),
    .value (LOAD_VAL),
    .dec   (w_dec),
    .zero  (w_zero)
  );

  // Storage is deliberately outside the reset domain so a program survives reset.
  always_ff @(posedge clock) begin
    if (prog_en) r_mem[prog_addr] <= prog_data;
  end

  for (genvar g = 0; g < BLOCK_W/8; g++) begin : g_byte
    assign w_block[8*g +: 8] = r_mem[{r_addr, 4'(g)}];
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_dec  = 1'b0;
    w_cap  = 1'b0;
    w_busy = 1'b0;
    case (r_state)
      IDLE: if (read) begin
        w_busy = 1'b1;
        w_load = 1'b1;
        w_next = BUSY;
      end
      BUSY: begin
        w_busy = 1'b1;
        if (!read)       w_next = IDLE;   // requester gave up: abort, keep old data
        else if (w_zero) begin
          w_cap  = 1'b1;
          w_next = DONE;
        end
        else             w_dec  = 1'b1;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr     <= '0;
      r_readdata <= '0;
    end else begin
      if (w_load) r_addr     <= address;
      if (w_cap)  r_readdata <= w_block;
    end
  end

  assign readdata = r_readdata;
  assign busywait = w_busy;
endmodule

// File: tb/tb_imem_block_reader.sv
// Randomized self-checking bench for imem_block_reader against a byte-array model.
module tb_imem_block_reader;
  localparam int AW  = 6;
  localparam int LAT = 4;

  logic          clock = 1'b0;
  logic          reset, read, busywait, prog_en;
  logic [AW-1:0] address;
  logic [127:0]  readdata;
  logic [AW+3:0] prog_addr;
  logic [7:0]    prog_data;

  int checks = 0, failures = 0;
  logic [7:0] mdl [0:1023];

  imem_block_reader #(.READ_LATENCY(LAT), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .read(read), .address(address),
    .readdata(readdata), .busywait(busywait), .prog_en(prog_en),
    .prog_addr(prog_addr), .prog_data(prog_data)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] mdl_block(input logic [AW-1:0] a);
    logic [127:0] b;
    for (int i = 0; i < 16; i++) b[8*i +: 8] = mdl[{a, 4'(i)}];
    return b;
  endfunction

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic prog_byte(input logic [AW+3:0] a, input logic [7:0] d);
    prog_en = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_en = 1'b0;
    mdl[a] = d;
  endtask

  // Issue a read and clock until busywait drops; returns edges counted from the
  // request cycle (acceptance edge included). Optionally swaps address mid-read.
  task automatic run_read(input logic [AW-1:0] a, input int chg_at, input logic [AW-1:0] alt,
                          output int edges, output logic [127:0] data, output bit held);
    logic [127:0] prev;
    read = 1'b1; address = a; edges = 0; held = 1'b1; prev = readdata;
    #1;
    do begin
      step();
      edges++;
      if (edges == chg_at) address = alt;
      if (busywait && readdata !== prev) held = 1'b0;
    end while (busywait && edges < 40);
    data = readdata;
  endtask

  task automatic test_reset();
    reset = 1'b1; read = 1'b0; address = '0; prog_en = 1'b0; prog_addr = '0; prog_data = '0;
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (readdata !== 128'h0) begin failures++; $display("FAIL reset_readdata got=%h want=0", readdata); end
    checks++; if (busywait !== 1'b0) begin failures++; $display("FAIL reset_busywait got=%b want=0", busywait); end
  endtask

  task automatic test_basic();
    int e; logic [127:0] d; bit h;
    for (int i = 0; i < 16; i++) prog_byte({4'(5), 4'(i)} , 8'(i));
    for (int i = 0; i < 16; i++) prog_byte({6'd1, 4'(i)}, 8'($urandom));
    for (int i = 0; i < 16; i++) prog_byte({6'd2, 4'(i)}, 8'($urandom));
    read = 1'b1; address = 6'd5; #1;
    checks++; if (busywait !== 1'b1) begin failures++; $display("FAIL basic_bw_req got=%b want=1", busywait); end
    run_read(6'd5, 0, '0, e, d, h);
    checks++; if (e !== LAT + 1) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", e, LAT + 1); end
    checks++; if (d !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      failures++; $display("FAIL basic_data got=%h want=0f0e0d0c0b0a09080706050403020100", d); end
    checks++; if (!h) begin failures++; $display("FAIL basic_hold got=0 want=1"); end
    read = 1'b0; #1;
    checks++; if (busywait !== 1'b0) begin failures++; $display("FAIL basic_done_bw got=%b want=0", busywait); end
    step();
    checks++; if (readdata !== mdl_block(6'd5)) begin failures++; $display("FAIL basic_idle_hold got=%h want=%h", readdata, mdl_block(6'd5)); end
  endtask

  task automatic test_addr_change();
    int e; logic [127:0] d; bit h;
    run_read(6'd5, 3, 6'd9, e, d, h);
    checks++; if (e !== LAT + 1) begin failures++; $display("FAIL addrchg_latency got=%0d want=%0d", e, LAT + 1); end
    checks++; if (d !== mdl_block(6'd5)) begin failures++; $display("FAIL addrchg_data got=%h want=%h", d, mdl_block(6'd5)); end
    read = 1'b0; step();
  endtask

  task automatic test_random();
    int e; logic [127:0] d; bit h;
    logic [AW-1:0] a, alt;
    for (int n = 0; n < 8; n++) begin
      a = AW'($urandom_range(0, 63));
      alt = AW'($urandom_range(0, 63));
      for (int i = 0; i < 16; i++) prog_byte({a, 4'(i)}, 8'($urandom));
      run_read(a, $urandom_range(0, 4), alt, e, d, h);
      checks++; if (e !== LAT + 1) begin failures++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", n, e, LAT + 1); end
      checks++; if (d !== mdl_block(a)) begin failures++; $display("FAIL rand_data[%0d] got=%h want=%h", n, d, mdl_block(a)); end
      checks++; if (!h) begin failures++; $display("FAIL rand_hold[%0d] got=0 want=1", n); end
      read = 1'b0; step();
    end
  endtask

  task automatic test_abort();
    int e; logic [127:0] d, prev; bit h;
    run_read(6'd5, 0, '0, e, d, h);
    read = 1'b0; step();
    prev = readdata;
    read = 1'b1; address = 6'd1;
    step(); step(); step();
    read = 1'b0; #1;
    checks++; if (busywait !== 1'b1) begin failures++; $display("FAIL abort_busy_bw got=%b want=1", busywait); end
    step();
    checks++; if (busywait !== 1'b0) begin failures++; $display("FAIL abort_idle_bw got=%b want=0", busywait); end
    step(); step(); step();
    checks++; if (readdata !== prev) begin failures++; $display("FAIL abort_data got=%h want=%h", readdata, prev); end
  endtask

  task automatic test_reset_mid();
    int e; logic [127:0] d; bit h;
    read = 1'b1; address = 6'd1;
    step(); step(); step();
    reset = 1'b1;
    prog_en = 1'b1; prog_addr = {6'd5, 4'd3}; prog_data = 8'h5C;
    step();
    mdl[{6'd5, 4'd3}] = 8'h5C;
    reset = 1'b0; prog_en = 1'b0; read = 1'b0; #1;
    checks++; if (readdata !== 128'h0) begin failures++; $display("FAIL rstmid_data got=%h want=0", readdata); end
    checks++; if (busywait !== 1'b0) begin failures++; $display("FAIL rstmid_bw got=%b want=0", busywait); end
    step();
    checks++; if (readdata !== 128'h0) begin failures++; $display("FAIL rstmid_idle got=%h want=0", readdata); end
    run_read(6'd5, 0, '0, e, d, h);
    checks++; if (d !== mdl_block(6'd5)) begin failures++; $display("FAIL rstmid_reread got=%h want=%h", d, mdl_block(6'd5)); end
    checks++; if (e !== LAT + 1) begin failures++; $display("FAIL rstmid_latency got=%0d want=%0d", e, LAT + 1); end
    read = 1'b0; step();
  endtask

  task automatic test_back_to_back();
    int e; logic [127:0] d; bit h;
    run_read(6'd1, 0, '0, e, d, h);
    checks++; if (d !== mdl_block(6'd1)) begin failures++; $display("FAIL b2b_data1 got=%h want=%h", d, mdl_block(6'd1)); end
    checks++; if (e !== LAT + 1) begin failures++; $display("FAIL b2b_latency1 got=%0d want=%0d", e, LAT + 1); end
    address = 6'd2;
    step();
    checks++; if (busywait !== 1'b1) begin failures++; $display("FAIL b2b_bw_after_done got=%b want=1", busywait); end
    run_read(6'd2, 0, '0, e, d, h);
    checks++; if (d !== mdl_block(6'd2)) begin failures++; $display("FAIL b2b_data2 got=%h want=%h", d, mdl_block(6'd2)); end
    checks++; if (e !== LAT + 1) begin failures++; $display("FAIL b2b_latency2 got=%0d want=%0d", e, LAT + 1); end
    read = 1'b0; step();
  endtask

  task automatic test_write_collision();
    int e; logic [127:0] d, old; bit h;
    old = mdl_block(6'd5);
    read = 1'b1; address = 6'd5;
    for (int i = 0; i < LAT; i++) step();
    checks++; if (busywait !== 1'b1) begin failures++; $display("FAIL coll_pre_bw got=%b want=1", busywait); end
    prog_en = 1'b1; prog_addr = {6'd5, 4'd0}; prog_data = 8'hAA;
    step();
    prog_en = 1'b0;
    mdl[{6'd5, 4'd0}] = 8'hAA;
    checks++; if (busywait !== 1'b0) begin failures++; $display("FAIL coll_done_bw got=%b want=0", busywait); end
    checks++; if (readdata !== old) begin failures++; $display("FAIL coll_old_data got=%h want=%h", readdata, old); end
    read = 1'b0; step();
    run_read(6'd5, 0, '0, e, d, h);
    checks++; if (d[7:0] !== 8'hAA) begin failures++; $display("FAIL coll_new_byte got=%h want=aa", d[7:0]); end
    checks++; if (d !== mdl_block(6'd5)) begin failures++; $display("FAIL coll_new_data got=%h want=%h", d, mdl_block(6'd5)); end
    read = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_addr_change();
    test_random();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_write_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
